// File: rtl/gate_bist_311_if.sv
// Bundle of the BIST controller's run-control, stimulus and result signals.
// The controller connects through the slave modport; the environment driving it uses master.
interface gate_bist_311_if;
    logic       start_311;
    logic [3:0] hold_311;
    logic [6:0] res_311;
    logic       a_311;
    logic       b_311;
    logic       busy_311;
    logic       done_311;
    logic       pass_311;
    logic [4:0] err_cnt_311;
    logic [3:0] fail_vec_311;

    modport master (
        output start_311, hold_311, res_311,
        input  a_311, b_311, busy_311, done_311, pass_311, err_cnt_311, fail_vec_311
    );

    modport slave (
        input  start_311, hold_311, res_311,
        output a_311, b_311, busy_311, done_311, pass_311, err_cnt_311, fail_vec_311
    );
endinterface

// File: rtl/gate_bist_311.sv
// Built-in self test for a two-input gate stage: walks {a,b} through 00..11,
// waits H settle cycles per vector, then counts mismatched result bits.
module gate_bist_311 (
    input logic            clk_311,
    input logic            rst_n_311,
    gate_bist_311_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0] state_reg;
    logic [1:0] vec_reg;
    logic [3:0] cnt_reg;
    logic       a_reg;
    logic       b_reg;
    logic       pass_reg;
    logic [4:0] err_reg;
    logic [3:0] fail_reg;

    logic [3:0] hold_eff;
    logic [6:0] expected;
    logic [6:0] diff;
    logic [2:0] diff_cnt;
    logic [4:0] err_next;

    // A hold of zero would skip settling entirely, so it is promoted to one cycle.
    assign hold_eff = (bus.hold_311 == 4'd0) ? 4'd1 : bus.hold_311;

    // Reference gate responses in res bit order: not, or, and, nand, nor, xor, xnor.
    assign expected = {~(a_reg ^ b_reg), a_reg ^ b_reg, ~(a_reg | b_reg),
                       ~(a_reg & b_reg), a_reg & b_reg, a_reg | b_reg, ~a_reg};
    assign diff     = bus.res_311 ^ expected;

    always_comb begin
        diff_cnt = 3'd0;
        for (int i = 0; i < 7; i++) begin
            diff_cnt = diff_cnt + {2'b00, diff[i]};
        end
    end

    // At most 7 bits per vector over 4 vectors, so 5 bits never wrap.
    assign err_next = err_reg + {2'b00, diff_cnt};

    always_ff @(posedge clk_311 or negedge rst_n_311) begin
        if (!rst_n_311) begin
            state_reg <= ST_IDLE;
            vec_reg   <= 2'd0;
            cnt_reg   <= 4'd0;
            a_reg     <= 1'b0;
            b_reg     <= 1'b0;
            pass_reg  <= 1'b0;
            err_reg   <= 5'd0;
            fail_reg  <= 4'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start_311) begin
                        state_reg <= ST_SETTLE;
                        vec_reg   <= 2'd0;
                        a_reg     <= 1'b0;
                        b_reg     <= 1'b0;
                        cnt_reg   <= hold_eff;
                        pass_reg  <= 1'b0;
                        err_reg   <= 5'd0;
                        fail_reg  <= 4'd0;
                    end
                end
                ST_SETTLE: begin
                    cnt_reg <= cnt_reg - 4'd1;
                    if (cnt_reg <= 4'd1) begin
                        state_reg <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    err_reg <= err_next;
                    if (diff_cnt != 3'd0) begin
                        fail_reg[vec_reg] <= 1'b1;
                    end
                    if (vec_reg == 2'd3) begin
                        state_reg <= ST_DONE;
                        pass_reg  <= (err_next == 5'd0);
                    end else begin
                        state_reg      <= ST_SETTLE;
                        vec_reg        <= vec_reg + 2'd1;
                        {a_reg, b_reg} <= vec_reg + 2'd1;
                        cnt_reg        <= hold_eff;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.a_311        = a_reg;
    assign bus.b_311        = b_reg;
    assign bus.busy_311     = (state_reg != ST_IDLE);
    assign bus.done_311     = (state_reg == ST_DONE);
    assign bus.pass_311     = pass_reg;
    assign bus.err_cnt_311  = err_reg;
    assign bus.fail_vec_311 = fail_reg;
endmodule
